// File: rtl/vga_segment_reader.sv
// vga_segment_reader: recovers the pixel position of a TinyVGA PMOD stream from
// its sync edges. It samples eight probe pixels of a seven-segment drawing and
// publishes them as a segment byte once per frame while the timing is locked.
module vga_segment_reader #(
  parameter int               H_TOTAL      = 800,
  parameter int               H_SYNC_START = 656,
  parameter int               V_TOTAL      = 525,
  parameter int               V_SYNC_START = 490,
  parameter int               V_ACTIVE     = 480,
  parameter logic [5:0]       FG_COLOR     = 6'b001111,
  // probe columns/lines, index 0..7 = a, b, c, d, e, f, g, dp
  parameter logic [7:0][9:0]  PROBE_COL    = {10'd512, 10'd320, 10'd216, 10'd216,
                                              10'd320, 10'd424, 10'd424, 10'd320},
  parameter logic [7:0][9:0]  PROBE_ROW    = {10'd440, 10'd239, 10'd135, 10'd344,
                                              10'd448, 10'd344, 10'd135, 10'd32}
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] vga_in,
  output logic [7:0] seg,
  output logic       seg_valid,
  output logic       locked,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC   = 10'(H_SYNC_START);
  localparam logic [9:0] H_RELOAD = 10'(H_SYNC_START + 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_SYNC   = 10'(V_SYNC_START);
  localparam logic [9:0] V_COMMIT = 10'(V_ACTIVE);

  // s1 is the full input byte; the second stage only feeds edge detection,
  // so it keeps just the two sync bits {hsync, vsync}
  logic [7:0] s1_q;
  logic [1:0] s2Sync_q;

  logic [9:0] hCnt_q, hCnt_d;
  logic [9:0] vCnt_q, vCnt_d;
  logic [1:0] hMatch_q, hMatch_d;
  logic [1:0] vMatch_q, vMatch_d;
  logic       hLocked_q, hLocked_d;
  logic       vLocked_q, vLocked_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] seg_q, seg_d;
  logic       segValid_q, segValid_d;
  logic [7:0] frameCnt_q, frameCnt_d;

  logic [5:0] rgb;
  logic       hFall;
  logic       vFall;
  logic       hWrap;
  logic       commit;

  // Unpack colour and detect sync falling edges on the pixel sitting in s1
  always_comb begin
    rgb    = {s1_q[0], s1_q[4], s1_q[1], s1_q[5], s1_q[2], s1_q[6]};
    hFall  = s2Sync_q[1] & ~s1_q[7];
    vFall  = s2Sync_q[0] & ~s1_q[3];
    hWrap  = ~hFall & (hCnt_q == H_LAST);
    commit = (hCnt_q == 10'd0) & (vCnt_q == V_COMMIT) & hLocked_q & vLocked_q;
  end

  // Free-running position counters, re-anchored on every sync falling edge
  always_comb begin
    hCnt_d = hCnt_q + 10'd1;
    vCnt_d = vCnt_q;
    if (hFall) begin
      hCnt_d = H_RELOAD;
    end else if (hWrap) begin
      hCnt_d = 10'd0;
    end
    if (vFall) begin
      vCnt_d = V_SYNC;
    end else if (hWrap) begin
      vCnt_d = (vCnt_q == V_LAST) ? 10'd0 : vCnt_q + 10'd1;
    end
  end

  // Lock tracking: a sync edge that lands where the counters predicted builds
  // confidence, any misplaced edge throws the lock away at once
  always_comb begin
    hMatch_d = hMatch_q;
    vMatch_d = vMatch_q;
    if (hFall) begin
      if (hCnt_q == H_SYNC) begin
        hMatch_d = (hMatch_q == 2'd3) ? 2'd3 : hMatch_q + 2'd1;
      end else begin
        hMatch_d = 2'd0;
      end
    end
    if (vFall) begin
      if (vCnt_q == V_SYNC) begin
        vMatch_d = (vMatch_q == 2'd2) ? 2'd2 : vMatch_q + 2'd1;
      end else begin
        vMatch_d = 2'd0;
      end
    end
    hLocked_d = (hMatch_d == 2'd3);
    vLocked_d = (vMatch_d == 2'd2);
  end

  // Sample probe pixels into the shadow byte and publish it at the commit point
  always_comb begin
    shadow_d   = shadow_q;
    seg_d      = seg_q;
    segValid_d = 1'b0;
    frameCnt_d = frameCnt_q;
    for (int i = 0; i < 8; i++) begin
      if ((hCnt_q == PROBE_COL[i]) && (vCnt_q == PROBE_ROW[i])) begin
        shadow_d[i] = (rgb == FG_COLOR);
      end
    end
    if (commit) begin
      seg_d      = shadow_q;
      segValid_d = 1'b1;
      frameCnt_d = frameCnt_q + 8'd1;
    end
  end

  // State register for the whole reader
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 8'd0;
      s2Sync_q   <= 2'd0;
      hCnt_q     <= 10'd0;
      vCnt_q     <= 10'd0;
      hMatch_q   <= 2'd0;
      vMatch_q   <= 2'd0;
      hLocked_q  <= 1'b0;
      vLocked_q  <= 1'b0;
      shadow_q   <= 8'd0;
      seg_q      <= 8'd0;
      segValid_q <= 1'b0;
      frameCnt_q <= 8'd0;
    end else begin
      s1_q       <= vga_in;
      s2Sync_q   <= {s1_q[7], s1_q[3]};
      hCnt_q     <= hCnt_d;
      vCnt_q     <= vCnt_d;
      hMatch_q   <= hMatch_d;
      vMatch_q   <= vMatch_d;
      hLocked_q  <= hLocked_d;
      vLocked_q  <= vLocked_d;
      shadow_q   <= shadow_d;
      seg_q      <= seg_d;
      segValid_q <= segValid_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  assign seg       = seg_q;
  assign seg_valid = segValid_q;
  assign locked    = hLocked_q & vLocked_q;
  assign frame_cnt = frameCnt_q;

endmodule

// File: doc/vga_segment_reader.md
VGA_SEGMENT_READER -- requirements
Module: vga_segment_reader

Interface
REQ-001 Parameter H_TOTAL, default 800, pixel clocks per line.
REQ-002 Parameter H_SYNC_START, default 656, pixel column at which hsync first goes low.
REQ-003 Parameter V_TOTAL, default 525, lines per frame.
REQ-004 Parameter V_SYNC_START, default 490, line at which vsync first goes low.
REQ-005 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 Parameter FG_COLOR, default 6'b001111, 6-bit RRGGBB colour that marks a lit segment.
REQ-007 One clock and one asynchronous, active-low reset, as follows.
REQ-008 clk  input  1  pixel clock, rising edge.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 vga_in  input  8  TinyVGA PMOD byte {hsync, B0, G0, R0, vsync, B1, G1, R1}, bit 7 to bit 0.
REQ-011 seg  output  8  decoded segments {dp, g, f, e, d, c, b, a}.
REQ-012 seg_valid  output  1  one-cycle pulse when seg is updated.
REQ-013 locked  output  1  h_locked AND v_locked.
REQ-014 frame_cnt  output  8  count of committed frames.

Function
REQ-015 Input path: vga_in is registered into s1 every cycle, and s1 is copied into s2 every cycle.
REQ-016 Colour unpack: rgb = {s1[0], s1[4], s1[1], s1[5], s1[2], s1[6]}, giving {R1, R0, G1, G0, B1, B0}.
REQ-017 h_fall = s2.hsync & ~s1.hsync, and v_fall = s2.vsync & ~s1.vsync.
REQ-018 h_cnt (10 bit) holds the column of the pixel in s1.
- On h_fall, next h_cnt = H_SYNC_START+1.
- Otherwise h_cnt increments, wrapping from H_TOTAL-1 to 0.
REQ-019 v_cnt (10 bit) holds the line of the pixel in s1.
- On v_fall, v_cnt loads V_SYNC_START.
- Otherwise v_cnt increments when h_cnt wraps, wrapping from V_TOTAL-1 to 0.
- When v_fall and an h_cnt wrap occur in the same cycle, v_fall wins.
REQ-020 Horizontal lock:
- On h_fall with h_cnt == H_SYNC_START, the 2-bit match counter increments, saturating at 3.
- On h_fall with h_cnt != H_SYNC_START, the counter clears to 0 and h_locked clears.
- h_locked = (counter == 3).
REQ-021 Vertical lock:
- On v_fall with v_cnt == V_SYNC_START (the value predicted before the load), the 2-bit counter increments, saturating at 2.
- On a v_fall mismatch, the counter clears.
- v_locked = (counter == 2).
REQ-022 Probe points (column, line):
- a = (320, 32), b = (424, 135), c = (424, 344), d = (320, 448)
- e = (216, 344), f = (216, 135), g = (320, 239), dp = (512, 440)
REQ-023 When (h_cnt, v_cnt) equals a probe point, the matching shadow bit takes (rgb == FG_COLOR); all other shadow bits hold.
REQ-024 Commit occurs in the cycle where h_cnt == 0, v_cnt == V_ACTIVE and locked == 1. On commit:
- seg <= shadow
- seg_valid pulses high for exactly 1 cycle
- frame_cnt increments, wrapping from 255 to 0
REQ-025 When not locked at the commit point: no commit, seg holds, seg_valid stays 0, frame_cnt holds.
REQ-026 Latency: a probe pixel on vga_in reaches the shadow register 2 clocks later; seg changes only at commit.
REQ-027 Loss of lock mid-frame takes effect in the next cycle; relock requires the full counts of REQ-020 and REQ-021.

Reset
REQ-028 While rst_n is low, all of the following are 0: s1, s2, h_cnt, v_cnt, both match counters, h_locked, v_locked, shadow, seg, seg_valid, frame_cnt.
REQ-029 Reset asserted mid-frame clears state immediately, with no partial commit; after release, lock is reacquired per REQ-020 and REQ-021.

Verification
REQ-030 Reset: drive rst_n low with vga_in = 0xFF -> all outputs are 0 and locked = 0.
REQ-031 Ideal 640x480 stream with only a and g drawn in FG_COLOR:
- locked = 1 after the 3rd vsync falling edge.
- The first seg_valid occurs at line 480 of the next frame, with seg = 0x41 and frame_cnt = 1.
REQ-032 All eight segments FG_COLOR, with pink 6'b110111 elsewhere -> seg = 0xFF. The same frame with the dp disc replaced by pink -> seg = 0x7F.
REQ-033 Inject one hsync falling edge 1 cycle early on line 100:
- h_locked drops in the next cycle.
- No seg_valid in that frame; frame_cnt holds.
- seg_valid resumes once 3 matching hsync edges are seen and line 480 is reached.
REQ-034 Pulse rst_n low at (300, 200) while locked with seg = 0x41 -> seg = 0, frame_cnt = 0; first post-reset seg_valid only after relock.
REQ-035 Run 256 locked frames -> frame_cnt wraps from 255 to 0 on the 256th commit; seg_valid count = 256.
